// File: rtl/matrix_bus_arbiter_if.sv
// Requester-side and matrix-pin signals of the LED-matrix write bus arbiter.
// The slave modport is the arbiter; the master modport is whoever drives requests and watches the pins.
interface matrix_bus_arbiter_if #(
   parameter int WORD_W = 16
);
   logic [1:0]        req;
   logic [WORD_W-1:0] word0;
   logic [WORD_W-1:0] word1;
   logic [1:0]        ack;
   logic              gnt_id;
   logic              busy;
   logic              done;
   logic              cs;
   logic              wr;
   logic              data;

   modport slave (
      input  req, word0, word1,
      output ack, gnt_id, busy, done, cs, wr, data
   );

   modport master (
      output req, word0, word1,
      input  ack, gnt_id, busy, done, cs, wr, data
   );
endinterface

// File: rtl/matrix_bus_arbiter.sv
// Two-requester arbiter and MSB-first serializer for the LED-matrix cs/wr/data bus.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise requester 0 wins ties.
//
// Handshake: req[k] is a level request and word<k> must be held stable while it is high;
// ack[k] pulses for one cycle on the edge the word is captured, after which the requester may
// change the word or drop req. A req still high after ack is taken as a further word.
module matrix_bus_arbiter #(
   parameter int WORD_W = 16,
   parameter int HALF   = 2,
   parameter int GAP    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   matrix_bus_arbiter_if.slave   bus,
   output logic [1:0]            dbg_state_o
);

   localparam int HW = (HALF   > 1) ? $clog2(HALF)   : 1;
   localparam int GW = (GAP    > 1) ? $clog2(GAP)    : 1;
   localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      GAP_S = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     hcnt_q, hcnt_d;
   logic [GW-1:0]     gcnt_q, gcnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [WORD_W-1:0] sh_q, sh_d;
   logic              cs_q, cs_d;
   logic              wr_q, wr_d;
   logic              data_q, data_d;
   logic [1:0]        ack_q, ack_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              gnt_q, gnt_d;
   logic              win;
`ifdef ARB_ROUND_ROBIN_EN
   logic              last_q, last_d;
`endif

   // Winner is only meaningful when some request is pending.
   always_comb begin
      win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.req == 2'b11) begin
         win = ~last_q;
      end else begin
         win = bus.req[1];
      end
`else
      win = ~bus.req[0];
`endif
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      gcnt_d  = gcnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      cs_d    = cs_q;
      wr_d    = wr_q;
      data_d  = data_q;
      ack_d   = 2'b00;
      done_d  = 1'b0;
      busy_d  = busy_q;
      gnt_d   = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               ack_d   = win ? 2'b10 : 2'b01;
               sh_d    = win ? bus.word1 : bus.word0;
               gnt_d   = win;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
               wr_d    = 1'b0;
               data_d  = sh_d[WORD_W-1];
               hcnt_d  = '0;
               bit_d   = '0;
               state_d = WR_LO;
`ifdef ARB_ROUND_ROBIN_EN
               last_d  = win;
`endif
            end
         end
         WR_LO: begin
            if (hcnt_q == HALF_LAST) begin
               hcnt_d  = '0;
               wr_d    = 1'b1;
               state_d = WR_HI;
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         WR_HI: begin
            if (hcnt_q == HALF_LAST) begin
               hcnt_d = '0;
               if (bit_q == BIT_LAST) begin
                  // wr stays high through cs rise so the chip never sees an extra edge.
                  bit_d   = '0;
                  cs_d    = 1'b1;
                  data_d  = 1'b0;
                  done_d  = 1'b1;
                  gcnt_d  = '0;
                  state_d = GAP_S;
               end else begin
                  bit_d   = bit_q + BW'(1);
                  sh_d    = sh_q << 1;
                  data_d  = sh_d[WORD_W-1];
                  wr_d    = 1'b0;
                  state_d = WR_LO;
               end
            end else begin
               hcnt_d = hcnt_q + HW'(1);
            end
         end
         GAP_S: begin
            if (gcnt_q == GAP_LAST) begin
               gcnt_d  = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               gcnt_d = gcnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hcnt_q  <= '0;
         gcnt_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b1;
         wr_q    <= 1'b1;
         data_q  <= 1'b0;
         ack_q   <= 2'b00;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         gnt_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         gcnt_q  <= gcnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cs_q    <= cs_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         gnt_q   <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_q  <= last_d;
`endif
      end
   end

   assign bus.ack    = ack_q;
   assign bus.done   = done_q;
   assign bus.busy   = busy_q;
   assign bus.gnt_id = gnt_q;
   assign bus.cs     = cs_q;
   assign bus.wr     = wr_q;
   assign bus.data   = data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_bus_arbiter.sv
// Directed bench for matrix_bus_arbiter (WORD_W=16, HALF=2, GAP=2); a pin-level monitor
// deserializes each transfer and compares {gnt_id, word} against the expected queue.
module tb_matrix_bus_arbiter;

   localparam int WORD_W = 16;
   localparam int HALF   = 2;
   localparam int GAP    = 2;
   localparam int SB_W   = WORD_W + 1;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   matrix_bus_arbiter_if #(.WORD_W(WORD_W)) bus ();

   matrix_bus_arbiter #(
      .WORD_W(WORD_W),
      .HALF  (HALF),
      .GAP   (GAP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .dbg_state_o(dbg_state)
   );

   int tests;
   int failed;

   logic [SB_W-1:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- pin monitor / scoreboard ----------------
   logic [WORD_W-1:0] rx;
   int   rx_bits;
   int   cs_low_cnt;
   int   done_cnt;
   int   ack_cnt;
   int   xfer_cnt;
   int   viol_data;
   int   viol_pulse;
   logic wr_prev, cs_prev, data_prev, done_prev;
   logic [1:0] ack_prev;

   always @(negedge clk) begin
      if (reset) begin
         rx         = '0;
         rx_bits    = 0;
         cs_low_cnt = 0;
         wr_prev    = 1'b1;
         cs_prev    = 1'b1;
         data_prev  = 1'b0;
         done_prev  = 1'b0;
         ack_prev   = 2'b00;
      end else begin
         if (!bus.cs) begin
            cs_low_cnt++;
            if (bus.wr && !wr_prev) begin
               rx = {rx[WORD_W-2:0], bus.data};
               rx_bits++;
            end
            if (bus.wr && wr_prev && (bus.data != data_prev)) viol_data++;
         end
         if (bus.done) done_cnt++;
         if (bus.done && done_prev) viol_pulse++;
         if (bus.ack != 2'b00) ack_cnt++;
         if ((bus.ack & ack_prev) != 2'b00) viol_pulse++;
         if (bus.cs && !cs_prev) begin
            xfer_cnt++;
            check("done_at_cs_rise", {31'd0, bus.done}, 32'd1);
            check("wr_high_at_cs_rise", {31'd0, bus.wr}, 32'd1);
            check("cs_low_cycles", cs_low_cnt, WORD_W * 2 * HALF);
            check("wr_rising_edges", rx_bits, WORD_W);
            check("sb_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("gnt_and_word", {bus.gnt_id, rx}, exp_q.pop_front());
            cs_low_cnt = 0;
            rx_bits    = 0;
         end
         wr_prev   = bus.wr;
         cs_prev   = bus.cs;
         data_prev = bus.data;
         done_prev = bus.done;
         ack_prev  = bus.ack;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ack(input string tag, input int budget);
      logic got;
      got = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (bus.ack != 2'b00) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, got}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      logic got;
      got = 1'b0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, got}, 32'd1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   int n;
   int acks_seen;
   int cs_low_seen;
   logic [1:0] gnt_exp[4];

   initial begin
      tests     = 0;
      failed    = 0;
      done_cnt  = 0;
      ack_cnt   = 0;
      xfer_cnt  = 0;
      viol_data = 0;
      viol_pulse = 0;
      bus.req   = 2'b00;
      bus.word0 = '0;
      bus.word1 = '0;
      reset     = 1'b1;
      apply_reset();

      // reset state
      check("rst_cs",   {31'd0, bus.cs},     32'd1);
      check("rst_wr",   {31'd0, bus.wr},     32'd1);
      check("rst_data", {31'd0, bus.data},   32'd0);
      check("rst_ack",  {30'd0, bus.ack},    32'd0);
      check("rst_done", {31'd0, bus.done},   32'd0);
      check("rst_busy", {31'd0, bus.busy},   32'd0);
      check("rst_gnt",  {31'd0, bus.gnt_id}, 32'd0);

      // single transfer of 16'h8001 from requester 0
      bus.word0 = 16'h8001;
      bus.req   = 2'b01;
      exp_q.push_back({1'b0, 16'h8001});
      wait_ack("single_ack_seen", 10);
      check("single_ack_val", {30'd0, bus.ack}, 32'd1);
      bus.req = 2'b00;
      @(negedge clk);
      check("single_ack_one_cycle", {30'd0, bus.ack}, 32'd0);
      check("single_busy_during", {31'd0, bus.busy}, 32'd1);
      wait_done("single_done_seen", 200);
      n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("single_busy_drop_delay", n, 2);

      // back-to-back from requester 0 with req held
      bus.word0 = 16'h1234;
      bus.req   = 2'b01;
      exp_q.push_back({1'b0, 16'h1234});
      exp_q.push_back({1'b0, 16'hC3C3});
      wait_ack("b2b_ack1_seen", 10);
      bus.word0 = 16'hC3C3;
      wait_done("b2b_done1_seen", 200);
      n = 0;
      while (bus.cs && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_cs_rise_to_fall", n, GAP + 1);
      check("b2b_ack2_val", {30'd0, bus.ack}, 32'd1);
      bus.req = 2'b00;
      wait_done("b2b_done2_seen", 200);
      repeat (4) @(negedge clk);

      // reset mid-transfer: requester 1 word is abandoned
      bus.word1 = 16'hBEEF;
      bus.req   = 2'b10;
      wait_ack("abort_ack_seen", 10);
      check("abort_ack_val", {30'd0, bus.ack}, 32'd2);
      bus.req = 2'b00;
      repeat (30) @(negedge clk);
      check("abort_cs_low_before", {31'd0, bus.cs}, 32'd0);
      reset = 1'b1;
      #1;
      check("abort_cs",   {31'd0, bus.cs},   32'd1);
      check("abort_wr",   {31'd0, bus.wr},   32'd1);
      check("abort_data", {31'd0, bus.data}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // contention, four transfers with both requesting
`ifdef ARB_ROUND_ROBIN_EN
      gnt_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
      gnt_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      bus.word0 = 16'hA5A5;
      bus.word1 = 16'h5A5A;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(gnt_exp[i][0] ? {1'b1, 16'h5A5A} : {1'b0, 16'hA5A5});
      end
      bus.req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_ack("cont_ack_seen", 200);
         check("cont_ack_val", {30'd0, bus.ack}, gnt_exp[i][0] ? 32'd2 : 32'd1);
         check("cont_gnt_id", {31'd0, bus.gnt_id}, {31'd0, gnt_exp[i][0]});
         if (i == 3) bus.req = 2'b00;
      end
      wait_done("cont_done_last", 200);
      repeat (4) @(negedge clk);

      // late request from requester 1 during requester 0 transfer
      bus.word0 = 16'h0F0F;
      bus.req   = 2'b01;
      exp_q.push_back({1'b0, 16'h0F0F});
      exp_q.push_back({1'b1, 16'hF00D});
      wait_ack("late_ack0_seen", 10);
      bus.req = 2'b00;
      repeat (20) @(negedge clk);
      bus.word1 = 16'hF00D;
      bus.req   = 2'b10;
      wait_done("late_done0_seen", 200);
      n = 0;
      while (bus.ack == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("late_ack1_delay", n, GAP + 1);
      check("late_ack1_val", {30'd0, bus.ack}, 32'd2);
      bus.req = 2'b00;
      wait_done("late_done1_seen", 200);

      // one-cycle glitch request during GAP is ignored
      @(negedge clk);
      bus.req = 2'b10;
      @(negedge clk);
      bus.req = 2'b00;
      acks_seen   = 0;
      cs_low_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.ack != 2'b00) acks_seen++;
         if (!bus.cs) cs_low_seen++;
      end
      check("glitch_no_ack", acks_seen, 0);
      check("glitch_cs_high", cs_low_seen, 0);

      // totals
      check("sb_drained",      exp_q.size(), 0);
      check("xfer_total",      xfer_cnt, 9);
      check("done_total",      done_cnt, 9);
      check("ack_total",       ack_cnt, 10);
      check("data_stable_whi", viol_data, 0);
      check("single_pulses",   viol_pulse, 0);
      check("final_idle_state", {30'd0, dbg_state}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
